uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver; successor to the fixed 8-bit simple receiver. Oversampled serial_rx in,
//  configurable data width/parity/stop, 3-sample majority vote, error flags and valid/ready handoff.
//  Sits between the pad-side serial line and the byte consumer (FIFO/command parser) in the clk domain.
// PARAMETERS
//  CLK_FREQ_HZ  33330000  system clock frequency, Hz
//  BAUD_RATE    115200    line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer divide, 289 at defaults)
//  DATA_BITS    8         data bits per frame, legal 5..9, LSB first
//  PARITY       0         0 none, 1 odd, 2 even
//  STOP         1         stop bits, 1 or 2
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  serial_rx    in   1          asynchronous serial line, idle high
//  rx_data      out  DATA_BITS  received word, stable while rx_valid=1
//  rx_valid     out  1          word available; held until accepted
//  rx_ready     in   1          consumer accept; transfer when rx_valid & rx_ready
//  parity_err   out  1          parity mismatch for word on rx_data (0 when PARITY=0)
//  frame_err    out  1          any stop bit sampled 0 for word on rx_data
//  rx_overrun   out  1          1-cycle pulse: frame completed while rx_valid still 1; frame dropped
//  break_det    out  1          1-cycle pulse on line break (see CONFIGURATION); tied 0 when disabled
// BEHAVIOUR
//  - Reset: all outputs 0, rx_data 0, state IDLE, 2-FF sync flops reset to 1 (no false start on release).
//  - serial_rx through 2-FF synchroniser -> rx_s; edge detector uses registered rx_s_d.
//  - HALF = CLKS_PER_BIT/2; bit counter width $clog2(CLKS_PER_BIT); elaboration error if CLKS_PER_BIT < 8.
//  - Per bit, counter runs 0..CLKS_PER_BIT-1; samples at HALF-1, HALF, HALF+1; bit = majority (2 of 3),
//    decided at HALF+1.
//  - States: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
//  - IDLE: rx_s_d=1 & rx_s=0 -> START, counter cleared to 0 in same cycle.
//  - START: majority at HALF+1 = 1 -> false start, back to IDLE, no output; = 0 -> DATA.
//  - DATA: DATA_BITS bits shifted in LSB first; after last bit -> PARITY or STOP.
//  - PARITY: compare against XOR of data (odd: XOR^bit must be 1; even: must be 0).
//  - STOP: sample STOP bits; after decision of last stop bit (its mid-point) return to IDLE immediately,
//    so a start edge in the second half of the stop bit is accepted.
//  - Completion (cycle after last stop decision): if rx_valid=0 -> load rx_data, parity_err, frame_err,
//    set rx_valid. If rx_valid=1 (and not accepted that same cycle) -> pulse rx_overrun, held word and
//    flags unchanged. Accept and completion in the same cycle: new word loads, no overrun.
//  - rx_valid & rx_ready clears rx_valid next cycle; flags keep value until next load.
//  - Error frames are delivered (with flags), never silently dropped (except break, see below).
//  - Latency: rx_valid rises 1 clk after mid-point (HALF+1) of final stop bit, + 2 clk synchroniser.
//  - rst_n asserted mid-frame: immediate return to reset values; partial frame discarded.
// CONFIGURATION
//  UART_RX_BREAK_DETECT_EN defined: frame with all data, parity and stop samples 0 is a break ->
//    break_det pulses 1 clk at completion, no word loaded, rx_valid unchanged; receiver then waits in
//    IDLE for rx_s=1 before accepting a new start edge.
//  Undefined: break_det tied 0; such a frame is delivered as rx_data=0 with frame_err=1.
// TESTING (clk 30 ns, defaults, CLKS_PER_BIT=289)
//  - 8N1 frame 0x88, rx_ready=1 -> rx_valid 1 clk, rx_data=0x88, parity_err=0, frame_err=0.
//  - Low glitch of 100 clk on idle line -> no rx_valid, state back in IDLE, next 0x55 frame received.
//  - PARITY=2, send 0xA5 with parity bit 1 -> rx_data=0xA5, parity_err=1; parity bit 0 -> parity_err=0.
//  - Frame 0x3C with stop bit 0 -> rx_data=0x3C, frame_err=1; following valid frame 0x3D clears flag.
//  - rx_ready=0, frames 0x11 then 0x22 -> rx_overrun pulse at 2nd completion, rx_data stays 0x11.
//  - rst_n low during data bit 4 of 0xFF -> all outputs 0; clean 0x81 frame after release received.
//  - With UART_RX_BREAK_DETECT_EN: line low 12 bit times -> break_det pulse, rx_valid stays 0.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver.
// The serial line passes through a 2-FF synchroniser. Each bit is decided by
// a 2-of-3 majority vote around the bit centre. Received words and their
// error flags are handed off to the consumer with valid/ready.
// Optional feature macro: UART_RX_BREAK_DETECT_EN. When it is defined, an
// all-zero frame is reported on break_det instead of being delivered as a word.
`timescale 1ns/1ps

module uart_rx_param #(
  parameter int CLK_FREQ_HZ = 33330000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP        = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_overrun,
  output logic                 break_det
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STP_LAST = IDX_W'(STOP - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_BREAK_DETECT_EN
  localparam logic [2:0] S_BRKW   = 3'd5;
`endif

  // Refuse configurations the sampling scheme or framing cannot support.
  if (CLKS_PER_BIT < 8) begin : g_cpb_chk
    $error("uart_rx_param: CLKS_PER_BIT must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP < 1 || STOP > 2) begin : g_stop_chk
    $error("uart_rx_param: STOP must be 1 or 2");
  end

  // 2-of-3 majority vote over the three centre samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity check: odd needs data^parity = 1, even needs data^parity = 0.
  function automatic logic calc_par_err(input logic [DATA_BITS-1:0] d, input logic p);
    if (PARITY == 1)      return ~(^d ^ p);
    else if (PARITY == 2) return ^d ^ p;
    else                  return 1'b0;
  endfunction

  logic                 sync_p0;
  logic                 rx_s;
  logic                 rx_s_d;
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic                 samp0;
  logic                 samp1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_err;
  logic                 done;
  logic                 dec_now;
  logic                 bit_dec;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 all_zero;
  logic                 brk_frame;
`endif

  assign dec_now = (cnt == CNT_DEC);
  assign bit_dec = maj3(samp0, samp1, rx_s);

  // Synchroniser and edge-detect delay. Resetting to 1 keeps a release from looking like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      sync_p0 <= serial_rx;
      rx_s    <= sync_p0;
      rx_s_d  <= rx_s;
    end
  end

  // Sample capture and data/parity shifting. Stale contents are always overwritten before use.
  always_ff @(posedge clk) begin
    if (cnt == CNT_S0) samp0 <= rx_s;
    if (cnt == CNT_S1) samp1 <= rx_s;
    if (state == S_DATA && dec_now) shreg <= {bit_dec, shreg[DATA_BITS-1:1]};
    if (state == S_PARITY && dec_now) par_bit <= bit_dec;
  end

  // Frame sequencer: bit timing, bit/stop indexing and stop-error tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      stop_err <= 1'b0;
      done     <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      all_zero  <= 1'b0;
      brk_frame <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == S_IDLE || cnt == CNT_LAST) cnt <= '0;
      else                                    cnt <= cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (rx_s_d && !rx_s) begin
            state    <= S_START;
            idx      <= '0;
            stop_err <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero <= 1'b1;
`endif
          end
        end
        S_START: begin
          // A start bit that votes high at its centre was a glitch.
          if (dec_now && bit_dec) state <= S_IDLE;
          else if (cnt == CNT_LAST) state <= S_DATA;
        end
        S_DATA: begin
`ifdef UART_RX_BREAK_DETECT_EN
          if (dec_now) all_zero <= all_zero & ~bit_dec;
`endif
          if (cnt == CNT_LAST) begin
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
`ifdef UART_RX_BREAK_DETECT_EN
          if (dec_now) all_zero <= all_zero & ~bit_dec;
`endif
          if (cnt == CNT_LAST) state <= S_STOP;
        end
        S_STOP: begin
          if (dec_now) begin
            if (!bit_dec) stop_err <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero <= all_zero & ~bit_dec;
`endif
            // Leave at the centre of the last stop bit so that an early next start edge is caught.
            if (idx == STP_LAST) begin
              done  <= 1'b1;
              state <= S_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
              brk_frame <= all_zero & ~bit_dec;
              if (all_zero && !bit_dec) state <= S_BRKW;
`endif
            end
          end else if (cnt == CNT_LAST) begin
            idx <= idx + 1'b1;
          end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        S_BRKW: begin
          // The line has to go idle again before a new start edge can count.
          if (rx_s) state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output handoff: load on completion when the slot is free, otherwise flag an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (done) begin
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk_frame) begin
          // A break is not a word; the handoff slot is left alone.
        end else
`endif
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= calc_par_err(shreg, par_bit);
          frame_err  <= stop_err;
          rx_valid   <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  // One-cycle break indication at frame completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) break_det <= 1'b0;
    else        break_det <= done & brk_frame;
  end
`else
  assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed testbench for uart_rx_param. It drives an 8N1 instance (A) and an
// 8E1 instance (B) with a 30 ns clock. When UART_RX_BREAK_DETECT_EN is defined,
// the break case expects a break_det pulse instead of a delivered zero word.
`timescale 1ns/1ps

module tb_uart_rx_param;

  localparam int CPB = 33330000 / 115200;  // 289 clocks per bit

  logic       clk_tb = 1'b0;
  logic       rst_n;
  logic       serial_a, serial_b;
  logic       rx_ready_a, rx_ready_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic       parity_err_a, parity_err_b;
  logic       frame_err_a, frame_err_b;
  logic       rx_overrun_a, rx_overrun_b;
  logic       break_det_a, break_det_b;

  always #15 clk_tb = ~clk_tb;

  uart_rx_param u_dut_a (
    .clk(clk_tb), .rst_n(rst_n), .serial_rx(serial_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .parity_err(parity_err_a), .frame_err(frame_err_a),
    .rx_overrun(rx_overrun_a), .break_det(break_det_a)
  );

  uart_rx_param #(.PARITY(2)) u_dut_b (
    .clk(clk_tb), .rst_n(rst_n), .serial_rx(serial_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .parity_err(parity_err_b), .frame_err(frame_err_b),
    .rx_overrun(rx_overrun_b), .break_det(break_det_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handoff monitor, sampled on the falling edge.
  int         acc_a = 0, acc_b = 0, ovr_a = 0, ovr_b = 0, brk_a = 0, brk_b = 0, vhi_a = 0;
  logic [7:0] cap_data_a = '0, cap_data_b = '0;
  logic       cap_pe_a = 1'b0, cap_fe_a = 1'b0, cap_pe_b = 1'b0, cap_fe_b = 1'b0;

  always @(negedge clk_tb) begin
    if (rx_valid_a) vhi_a++;
    if (rx_valid_a && rx_ready_a) begin
      acc_a++; cap_data_a = rx_data_a; cap_pe_a = parity_err_a; cap_fe_a = frame_err_a;
    end
    if (rx_valid_b && rx_ready_b) begin
      acc_b++; cap_data_b = rx_data_b; cap_pe_b = parity_err_b; cap_fe_b = frame_err_b;
    end
    if (rx_overrun_a) ovr_a++;
    if (rx_overrun_b) ovr_b++;
    if (break_det_a) brk_a++;
    if (break_det_b) brk_b++;
  end

  task automatic hold_line(input int sel, input logic v, input int clks);
    if (sel == 0) serial_a = v;
    else          serial_b = v;
    repeat (clks) @(negedge clk_tb);
  endtask

  // par < 0 means no parity bit; otherwise par[0] is sent as the parity bit.
  task automatic send_frame(input int sel, input logic [7:0] d, input int par, input logic stop_v);
    hold_line(sel, 1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_line(sel, d[i], CPB);
    if (par >= 0) hold_line(sel, par[0], CPB);
    hold_line(sel, stop_v, CPB);
    hold_line(sel, 1'b1, 2 * CPB);
  endtask

  initial begin
    int a0, b0, o0, k0, v0;
    rst_n = 1'b0; serial_a = 1'b1; serial_b = 1'b1;
    rx_ready_a = 1'b1; rx_ready_b = 1'b1;
    repeat (5) @(negedge clk_tb);
    check_val("rst_data",    32'(rx_data_a),    32'h0);
    check_val("rst_valid",   32'(rx_valid_a),   32'h0);
    check_val("rst_par",     32'(parity_err_a), 32'h0);
    check_val("rst_frame",   32'(frame_err_a),  32'h0);
    check_val("rst_overrun", 32'(rx_overrun_a), 32'h0);
    check_val("rst_break",   32'(break_det_a),  32'h0);
    rst_n = 1'b1;
    hold_line(0, 1'b1, 2 * CPB);

    // Plain 8N1 frame.
    a0 = acc_a; v0 = vhi_a;
    send_frame(0, 8'h88, -1, 1'b1);
    check_val("f88_count", 32'(acc_a - a0), 32'd1);
    check_val("f88_vcyc",  32'(vhi_a - v0), 32'd1);
    check_val("f88_data",  32'(cap_data_a), 32'h88);
    check_val("f88_par",   32'(cap_pe_a),   32'h0);
    check_val("f88_frame", 32'(cap_fe_a),   32'h0);

    // Short low glitch must not start a frame.
    a0 = acc_a;
    hold_line(0, 1'b0, 100);
    hold_line(0, 1'b1, 2 * CPB);
    check_val("glitch_count", 32'(acc_a - a0), 32'd0);
    send_frame(0, 8'h55, -1, 1'b1);
    check_val("f55_count", 32'(acc_a - a0), 32'd1);
    check_val("f55_data",  32'(cap_data_a), 32'h55);

    // Even parity on instance B: 0xA5 has four ones, so parity bit 1 is wrong.
    b0 = acc_b;
    send_frame(1, 8'hA5, 1, 1'b1);
    check_val("pe1_count", 32'(acc_b - b0), 32'd1);
    check_val("pe1_data",  32'(cap_data_b), 32'hA5);
    check_val("pe1_par",   32'(cap_pe_b),   32'h1);
    check_val("pe1_frame", 32'(cap_fe_b),   32'h0);
    send_frame(1, 8'hA5, 0, 1'b1);
    check_val("pe0_count", 32'(acc_b - b0), 32'd2);
    check_val("pe0_data",  32'(cap_data_b), 32'hA5);
    check_val("pe0_par",   32'(cap_pe_b),   32'h0);

    // Bad stop bit, then a good frame clears the flag.
    a0 = acc_a;
    send_frame(0, 8'h3C, -1, 1'b0);
    check_val("fe_count", 32'(acc_a - a0), 32'd1);
    check_val("fe_data",  32'(cap_data_a), 32'h3C);
    check_val("fe_flag",  32'(cap_fe_a),   32'h1);
    send_frame(0, 8'h3D, -1, 1'b1);
    check_val("fe_clr_data", 32'(cap_data_a), 32'h3D);
    check_val("fe_clr_flag", 32'(cap_fe_a),   32'h0);

    // Overrun: consumer stalled across two frames.
    @(posedge clk_tb); #1 rx_ready_a = 1'b0;
    a0 = acc_a; o0 = ovr_a;
    send_frame(0, 8'h11, -1, 1'b1);
    send_frame(0, 8'h22, -1, 1'b1);
    check_val("ovr_pulse", 32'(ovr_a - o0), 32'd1);
    check_val("ovr_held",  32'(rx_data_a),  32'h11);
    check_val("ovr_valid", 32'(rx_valid_a), 32'h1);
    check_val("ovr_noacc", 32'(acc_a - a0), 32'd0);
    @(posedge clk_tb); #1 rx_ready_a = 1'b1;
    @(negedge clk_tb); @(negedge clk_tb);
    check_val("ovr_acc",      32'(acc_a - a0), 32'd1);
    check_val("ovr_acc_data", 32'(cap_data_a), 32'h11);
    check_val("ovr_vclr",     32'(rx_valid_a), 32'h0);

    // Reset during data bit 4 of 0xFF.
    hold_line(0, 1'b0, CPB);
    hold_line(0, 1'b1, 4 * CPB + CPB / 2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_tb);
    check_val("mid_rst_data",  32'(rx_data_a),  32'h0);
    check_val("mid_rst_valid", 32'(rx_valid_a), 32'h0);
    check_val("mid_rst_frame", 32'(frame_err_a), 32'h0);
    rst_n = 1'b1;
    hold_line(0, 1'b1, 2 * CPB);
    a0 = acc_a;
    send_frame(0, 8'h81, -1, 1'b1);
    check_val("f81_count", 32'(acc_a - a0), 32'd1);
    check_val("f81_data",  32'(cap_data_a), 32'h81);
    check_val("f81_frame", 32'(cap_fe_a),   32'h0);

    // Line held low for 12 bit times.
    a0 = acc_a; k0 = brk_a;
    hold_line(0, 1'b0, 12 * CPB);
    hold_line(0, 1'b1, 3 * CPB);
`ifdef UART_RX_BREAK_DETECT_EN
    check_val("brk_pulse", 32'(brk_a - k0), 32'd1);
    check_val("brk_noacc", 32'(acc_a - a0), 32'd0);
    check_val("brk_valid", 32'(rx_valid_a), 32'h0);
`else
    check_val("brk_pulse", 32'(brk_a - k0), 32'd0);
    check_val("brk_count", 32'(acc_a - a0), 32'd1);
    check_val("brk_data",  32'(cap_data_a), 32'h0);
    check_val("brk_frame", 32'(cap_fe_a),   32'h1);
`endif
    a0 = acc_a;
    send_frame(0, 8'h5A, -1, 1'b1);
    check_val("f5a_count", 32'(acc_a - a0), 32'd1);
    check_val("f5a_data",  32'(cap_data_a), 32'h5A);

    check_val("b_no_overrun", 32'(ovr_b), 32'd0);
    check_val("b_no_break",   32'(brk_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
